// File: rtl/crossbar_input_ctrl.sv
// -----------------------------------------------------------------------------
// crossbar_input_ctrl
//
// Purpose:
//   Per-ingress-port front end of the crossbar. Pops frames from the ingress
//   port's show-ahead FIFO and raises a one-hot request toward the
//   destination output's arbiter. While that arbiter's grant is held, it
//   streams the frame one word per cycle. After each frame the request drops
//   for one cycle (GAP), so the arbiter releases its hold between frames.
//   Frames addressed to an output index >= P_PORTS are read and discarded.
//
// Handshake:
//   A FIFO word is consumed on any cycle where fifo_rd_o=1. In ACTIVE this
//   happens when grant_i[dest_q] is high and the FIFO is non-empty. grant_i
//   may depend combinationally on request_o in the same cycle. Forwarded
//   words appear on data_o/last_o the cycle after they are read, qualified by
//   valid_o. There is no backpressure from downstream; the arbiter grant is
//   the only flow control.
//
// Parameters:
//   P_PORTS   number of crossbar outputs (>= 2)
//   P_DATA_W  data word width
//   P_DEST_W  destination field width
//
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   fifo_empty_i      ingress FIFO empty
//   fifo_data_i       FIFO head word (show-ahead)
//   fifo_last_i       head word is the last word of its frame
//   fifo_dest_i       destination of the frame (valid on its first word)
//   fifo_rd_o         pop the FIFO head this cycle
//   request_o         one-hot request to the output arbiters
//   grant_i           this input's grant bit from each output arbiter
//   data_o            forwarded word (registered)
//   valid_o           data_o valid
//   last_o            data_o is the last word of its frame
//   dest_o            destination of the current frame (crossbar column select)
//   frame_cnt_o       forwarded-frame count, 16-bit wrapping (stats build only)
//   drop_cnt_o        dropped-frame count, 16-bit wrapping (stats build only)
//   state_o           debug view of the FSM state (IDLE=0 ACTIVE=1 DROP=2 GAP=3)
//
// Build option:
//   CROSSBAR_INPUT_STATS_EN  when defined, adds frame_cnt_o / drop_cnt_o and
//                            their counters.
// -----------------------------------------------------------------------------
module crossbar_input_ctrl #(
    parameter int P_PORTS  = 3,
    parameter int P_DATA_W = 8,
    parameter int P_DEST_W = $clog2(P_PORTS)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                fifo_empty_i,
    input  logic [P_DATA_W-1:0] fifo_data_i,
    input  logic                fifo_last_i,
    input  logic [P_DEST_W-1:0] fifo_dest_i,
    output logic                fifo_rd_o,
    output logic [P_PORTS-1:0]  request_o,
    input  logic [P_PORTS-1:0]  grant_i,
    output logic [P_DATA_W-1:0] data_o,
    output logic                valid_o,
    output logic                last_o,
    output logic [P_DEST_W-1:0] dest_o,
`ifdef CROSSBAR_INPUT_STATS_EN
    output logic [15:0]         frame_cnt_o,
    output logic [15:0]         drop_cnt_o,
`endif
    output logic [1:0]          state_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DROP   = 2'd2,
        S_GAP    = 2'd3
    } state_e;

    // One extra bit so the port count itself is representable.
    localparam logic [P_DEST_W:0] L_PORTS = (P_DEST_W + 1)'(P_PORTS);

    state_e                state_q, state_d;
    logic [P_DEST_W-1:0]   dest_q, dest_d;
    logic [P_DATA_W-1:0]   data_q;
    logic                  valid_q;
    logic                  last_q;

    logic [P_PORTS-1:0]    dest_onehot;
    logic                  grant_sel;
    logic                  dest_ok;
    logic                  fifo_rd;
    logic                  rd_fwd;

    // -------------------------------------------------------------------------
    // Destination decode
    // -------------------------------------------------------------------------
    always_comb begin
        dest_onehot = '0;
        for (int k = 0; k < P_PORTS; k++) begin
            dest_onehot[k] = (dest_q == P_DEST_W'(k));
        end
    end

    // Masking with the one-hot vector ignores grant bits of other outputs.
    assign grant_sel = |(grant_i & dest_onehot);

    assign dest_ok = ({1'b0, fifo_dest_i} < L_PORTS);

    // -------------------------------------------------------------------------
    // FSM: next state and combinational outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        dest_d    = dest_q;
        fifo_rd   = 1'b0;
        request_o = '0;
        case (state_q)
            S_IDLE: begin
                // Latch the destination from the head word; no read yet.
                if (!fifo_empty_i) begin
                    dest_d  = fifo_dest_i;
                    state_d = dest_ok ? S_ACTIVE : S_DROP;
                end
            end
            S_ACTIVE: begin
                // The request stays up across grant/empty stalls so the
                // arbiter keeps this input selected for the whole frame.
                request_o = dest_onehot;
                if (grant_sel && !fifo_empty_i) begin
                    fifo_rd = 1'b1;
                    if (fifo_last_i) begin
                        state_d = S_GAP;
                    end
                end
            end
            S_DROP: begin
                if (!fifo_empty_i) begin
                    fifo_rd = 1'b1;
                    if (fifo_last_i) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                // One request-free cycle releases the arbiter's grant hold.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Only reads taken in ACTIVE are forwarded; DROP reads are discarded.
    assign rd_fwd = fifo_rd && (state_q == S_ACTIVE);

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            dest_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
            valid_q <= rd_fwd;
            last_q  <= rd_fwd & fifo_last_i;
            if (rd_fwd) begin
                data_q <= fifo_data_i;
            end
        end
    end

`ifdef CROSSBAR_INPUT_STATS_EN
    // -------------------------------------------------------------------------
    // Frame statistics (16-bit, wrap naturally)
    // -------------------------------------------------------------------------
    logic [15:0] frame_cnt_q;
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            if (valid_q && last_q) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if ((state_q == S_DROP) && fifo_rd && fifo_last_i) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    assign frame_cnt_o = frame_cnt_q;
    assign drop_cnt_o  = drop_cnt_q;
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign fifo_rd_o = fifo_rd;
    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign last_o    = last_q;
    assign dest_o    = dest_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_crossbar_input_ctrl.sv
// -----------------------------------------------------------------------------
// tb_crossbar_input_ctrl
//
// Directed bench for crossbar_input_ctrl (P_PORTS=3, P_DATA_W=8). A small
// show-ahead FIFO model feeds the DUT. grant_i is either tied to request_o
// or forced from the bench. Each scenario runs a fixed number of cycles from
// a hand-written table. Every table entry packs
//   {request_o, fifo_rd_o, valid_o, last_o, data_o}
// and is compared at the falling edge. last_o and data_o are only compared
// on cycles where valid_o is expected.
// -----------------------------------------------------------------------------
module tb_crossbar_input_ctrl;

  localparam int P_PORTS  = 3;
  localparam int P_DATA_W = 8;
  localparam int P_DEST_W = 2;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // DUT signals
  // ---------------------------------------------------------------------------
  logic                fifo_empty;
  logic [P_DATA_W-1:0] fifo_data;
  logic                fifo_last;
  logic [P_DEST_W-1:0] fifo_dest;
  logic                fifo_rd;
  logic [P_PORTS-1:0]  request;
  logic [P_PORTS-1:0]  grant;
  logic [P_DATA_W-1:0] data;
  logic                valid;
  logic                last;
  logic [P_DEST_W-1:0] dest;
  logic [1:0]          state;
`ifdef CROSSBAR_INPUT_STATS_EN
  logic [15:0]         frame_cnt;
  logic [15:0]         drop_cnt;
`endif

  crossbar_input_ctrl #(
    .P_PORTS  (P_PORTS),
    .P_DATA_W (P_DATA_W)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .fifo_empty_i (fifo_empty),
    .fifo_data_i  (fifo_data),
    .fifo_last_i  (fifo_last),
    .fifo_dest_i  (fifo_dest),
    .fifo_rd_o    (fifo_rd),
    .request_o    (request),
    .grant_i      (grant),
    .data_o       (data),
    .valid_o      (valid),
    .last_o       (last),
    .dest_o       (dest),
`ifdef CROSSBAR_INPUT_STATS_EN
    .frame_cnt_o  (frame_cnt),
    .drop_cnt_o   (drop_cnt),
`endif
    .state_o      (state)
  );

  // ---------------------------------------------------------------------------
  // FIFO model (show-ahead) and grant source
  // ---------------------------------------------------------------------------
  logic [10:0] mem [64];  // {last, dest[1:0], data[7:0]}
  int          wr_ptr = 0;
  int          rd_ptr = 0;

  assign fifo_empty = (rd_ptr == wr_ptr);
  assign {fifo_last, fifo_dest, fifo_data} = mem[rd_ptr[5:0]];

  always @(posedge clk) begin
    if (fifo_rd && !fifo_empty) rd_ptr <= rd_ptr + 1;
  end

  logic               grant_tie = 1'b1;
  logic [P_PORTS-1:0] grant_force = '0;
  assign grant = grant_tie ? request : grant_force;

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int tests_run = 0;
  int tests_failed = 0;

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic push_word(input logic [7:0] d, input logic [1:0] ds, input logic l);
    mem[wr_ptr[5:0]] = {l, ds, d};
    wr_ptr = wr_ptr + 1;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [13:0] exp_t [4] = '{
      {3'b000, 1'b0, 1'b0, 1'b0, 8'h00},
      {3'b100, 1'b1, 1'b0, 1'b0, 8'h00},
      {3'b000, 1'b0, 1'b1, 1'b1, 8'h5A},
      {3'b000, 1'b0, 1'b0, 1'b0, 8'h00}
    };
    logic [13:0] obs;
    #2 rst_n = 1'b0;
    push_word(8'h5A, 2'd2, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if ({fifo_rd, request, valid, last, data, dest, state} !== '0) begin
        tests_failed++;
        $display("FAIL reset_hold c%0d: rd=%b req=%b v=%b l=%b d=%h dest=%0d st=%0d, want all 0",
                 i, fifo_rd, request, valid, last, data, dest, state);
      end
`ifdef CROSSBAR_INPUT_STATS_EN
      tests_run++;
      if ({frame_cnt, drop_cnt} !== 32'h0) begin
        tests_failed++;
        $display("FAIL reset_cnt c%0d: frame=%0d drop=%0d, want 0 0", i, frame_cnt, drop_cnt);
      end
`endif
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i == 0) rst_n = 1'b1;
      @(negedge clk);
      obs = {request, fifo_rd, valid, exp_t[i][9] ? last : 1'b0, exp_t[i][9] ? data : 8'h00};
      tests_run++;
      if (obs !== exp_t[i]) begin
        tests_failed++;
        $display("FAIL reset_release c%0d: got %h want %h", i, obs, exp_t[i]);
      end
      if (i == 1) begin
        tests_run++;
        if (dest !== 2'd2) begin
          tests_failed++;
          $display("FAIL reset_dest: got %0d want 2", dest);
        end
      end
    end
  endtask

  task automatic test_stream();
    logic [13:0] exp_t [8] = '{
      {3'b000, 1'b0, 1'b0, 1'b0, 8'h00},
      {3'b010, 1'b1, 1'b0, 1'b0, 8'h00},
      {3'b010, 1'b1, 1'b1, 1'b0, 8'h11},
      {3'b010, 1'b1, 1'b1, 1'b0, 8'h12},
      {3'b010, 1'b1, 1'b1, 1'b0, 8'h13},
      {3'b000, 1'b0, 1'b1, 1'b1, 8'h14},
      {3'b000, 1'b0, 1'b0, 1'b0, 8'h00},
      {3'b000, 1'b0, 1'b0, 1'b0, 8'h00}
    };
    logic [13:0] obs;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        push_word(8'h11, 2'd1, 1'b0);
        push_word(8'h12, 2'd1, 1'b0);
        push_word(8'h13, 2'd1, 1'b0);
        push_word(8'h14, 2'd1, 1'b1);
      end
      @(negedge clk);
      obs = {request, fifo_rd, valid, exp_t[i][9] ? last : 1'b0, exp_t[i][9] ? data : 8'h00};
      tests_run++;
      if (obs !== exp_t[i]) begin
        tests_failed++;
        $display("FAIL stream c%0d: got %h want %h", i, obs, exp_t[i]);
      end
      if (i == 3) begin
        tests_run++;
        if (dest !== 2'd1) begin
          tests_failed++;
          $display("FAIL stream_dest: got %0d want 1", dest);
        end
      end
    end
  endtask

  // Grant withheld (other grant bits high), then a FIFO underrun mid-frame.
  task automatic test_stall();
    logic [13:0] exp_t [12] = '{
      {3'b000, 1'b0, 1'b0, 1'b0, 8'h00},
      {3'b010, 1'b0, 1'b0, 1'b0, 8'h00},
      {3'b010, 1'b0, 1'b0, 1'b0, 8'h00},
      {3'b010, 1'b0, 1'b0, 1'b0, 8'h00},
      {3'b010, 1'b1, 1'b0, 1'b0, 8'h00},
      {3'b010, 1'b1, 1'b1, 1'b0, 8'h11},
      {3'b010, 1'b0, 1'b1, 1'b0, 8'h12},
      {3'b010, 1'b0, 1'b0, 1'b0, 8'h00},
      {3'b010, 1'b1, 1'b0, 1'b0, 8'h00},
      {3'b010, 1'b1, 1'b1, 1'b0, 8'h13},
      {3'b000, 1'b0, 1'b1, 1'b1, 8'h14},
      {3'b000, 1'b0, 1'b0, 1'b0, 8'h00}
    };
    logic [13:0] obs;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        grant_tie   = 1'b0;
        grant_force = 3'b101;
        push_word(8'h11, 2'd1, 1'b0);
        push_word(8'h12, 2'd1, 1'b0);
      end
      if (i == 4) grant_force = 3'b111;
      if (i == 8) begin
        push_word(8'h13, 2'd1, 1'b0);
        push_word(8'h14, 2'd1, 1'b1);
      end
      @(negedge clk);
      obs = {request, fifo_rd, valid, exp_t[i][9] ? last : 1'b0, exp_t[i][9] ? data : 8'h00};
      tests_run++;
      if (obs !== exp_t[i]) begin
        tests_failed++;
        $display("FAIL stall c%0d: got %h want %h", i, obs, exp_t[i]);
      end
      if (i == 11) begin
        tests_run++;
        if (dest !== 2'd1) begin
          tests_failed++;
          $display("FAIL stall_dest: got %0d want 1", dest);
        end
      end
    end
    grant_tie   = 1'b1;
    grant_force = '0;
  endtask

  task automatic test_drop();
    logic [13:0] exp_t [6] = '{
      {3'b000, 1'b0, 1'b0, 1'b0, 8'h00},
      {3'b000, 1'b1, 1'b0, 1'b0, 8'h00},
      {3'b000, 1'b1, 1'b0, 1'b0, 8'h00},
      {3'b000, 1'b1, 1'b0, 1'b0, 8'h00},
      {3'b000, 1'b0, 1'b0, 1'b0, 8'h00},
      {3'b000, 1'b0, 1'b0, 1'b0, 8'h00}
    };
    logic [13:0] obs;
`ifdef CROSSBAR_INPUT_STATS_EN
    logic [15:0] drop_base = drop_cnt;
`endif
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        push_word(8'h21, 2'd3, 1'b0);
        push_word(8'h22, 2'd3, 1'b0);
        push_word(8'h23, 2'd3, 1'b1);
      end
      @(negedge clk);
      obs = {request, fifo_rd, valid, exp_t[i][9] ? last : 1'b0, exp_t[i][9] ? data : 8'h00};
      tests_run++;
      if (obs !== exp_t[i]) begin
        tests_failed++;
        $display("FAIL drop c%0d: got %h want %h", i, obs, exp_t[i]);
      end
      if (i == 1) begin
        tests_run++;
        if ({dest, state} !== {2'd3, 2'd2}) begin
          tests_failed++;
          $display("FAIL drop_state: dest=%0d st=%0d want dest=3 st=2", dest, state);
        end
      end
    end
`ifdef CROSSBAR_INPUT_STATS_EN
    tests_run++;
    if (drop_cnt - drop_base !== 16'd1) begin
      tests_failed++;
      $display("FAIL drop_cnt: got delta %0d want 1", drop_cnt - drop_base);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [13:0] exp_t [7] = '{
      {3'b000, 1'b0, 1'b0, 1'b0, 8'h00},
      {3'b001, 1'b1, 1'b0, 1'b0, 8'h00},
      {3'b000, 1'b0, 1'b1, 1'b1, 8'h31},
      {3'b000, 1'b0, 1'b0, 1'b0, 8'h00},
      {3'b001, 1'b1, 1'b0, 1'b0, 8'h00},
      {3'b000, 1'b0, 1'b1, 1'b1, 8'h32},
      {3'b000, 1'b0, 1'b0, 1'b0, 8'h00}
    };
    logic [13:0] obs;
`ifdef CROSSBAR_INPUT_STATS_EN
    logic [15:0] frame_base = frame_cnt;
`endif
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        push_word(8'h31, 2'd0, 1'b1);
        push_word(8'h32, 2'd0, 1'b1);
      end
      @(negedge clk);
      obs = {request, fifo_rd, valid, exp_t[i][9] ? last : 1'b0, exp_t[i][9] ? data : 8'h00};
      tests_run++;
      if (obs !== exp_t[i]) begin
        tests_failed++;
        $display("FAIL b2b c%0d: got %h want %h", i, obs, exp_t[i]);
      end
    end
`ifdef CROSSBAR_INPUT_STATS_EN
    tests_run++;
    if (frame_cnt - frame_base !== 16'd2) begin
      tests_failed++;
      $display("FAIL frame_cnt: got delta %0d want 2", frame_cnt - frame_base);
    end
`endif
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and final report
  // ---------------------------------------------------------------------------
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    test_reset();
    test_stream();
    test_stall();
    test_drop();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
